seg_scan_display: RTL

Time-multiplexed seven-segment driver for the watch's BCD digits. It sits directly downstream of the chained decimal digit counters and takes their 4-bit digit outputs as one flat bus. It scans one digit at a time onto a shared active-low segment bus and digit-enable bus. The full digit set is snapshotted once per frame so a rollover mid-scan never shows a torn time, and digits selected for editing can be blinked.

---
 rtl/seg_scan_display.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/seg_scan_display.sv
// -----------------------------------------------------------------------------
// seg_scan_display
//
// Time-multiplexed seven-segment driver. One digit at a time is driven onto a
// shared active-low segment bus and an active-low digit-enable bus. The whole
// digit bus is captured once per frame so a counter rollover in the middle of
// a scan never shows a mixed time. Digits selected for editing can be blinked.
//
// Optional feature macro: SEG_SCAN_DISPLAY_BLINK_EN
//   defined   - frame counter, blink phase and blink masking are built
//   undefined - blink_sel is ignored and digits never blink
//
// Parameters
//   DIGITS       number of scanned digits (2..8)
//   SCAN_DIV     clk_cin cycles each digit stays lit (>= 2)
//   BLINK_FRAMES completed frames per blink-phase toggle (>= 1)
//
// Ports
//   clk_cin     in   scan clock, rising edge
//   rst         in   asynchronous active-high reset
//   en          in   scan enable; low freezes scanning and darkens the display
//   digits_bcd  in   4*DIGITS, digit k in bits [4k+3:4k], digit 0 rightmost
//   blank_mask  in   DIGITS, bit k forces digit k dark (including dp)
//   dp_mask     in   DIGITS, bit k lights the decimal point of digit k
//   blink_sel   in   DIGITS, bit k makes digit k blink
//   seg         out  7, {g,f,e,d,c,b,a}, active low
//   dp          out  decimal point, active low
//   an          out  DIGITS, digit enables, active low
//   frame_done  out  one-cycle pulse per completed frame
// -----------------------------------------------------------------------------
module seg_scan_display #(
  parameter int DIGITS       = 6,
  parameter int SCAN_DIV     = 16,
  parameter int BLINK_FRAMES = 32
) (
  input  logic                clk_cin,
  input  logic                rst,
  input  logic                en,
  input  logic [4*DIGITS-1:0] digits_bcd,
  input  logic [DIGITS-1:0]   blank_mask,
  input  logic [DIGITS-1:0]   dp_mask,
  input  logic [DIGITS-1:0]   blink_sel,
  output logic [6:0]          seg,
  output logic                dp,
  output logic [DIGITS-1:0]   an,
  output logic                frame_done
);

  localparam int DIV_W = $clog2(SCAN_DIV);
  localparam int IDX_W = $clog2(DIGITS);

  localparam logic [DIV_W-1:0] DIV_ZERO = DIV_W'(0);
  localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_ZERO = IDX_W'(0);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);

  localparam logic [6:0] SEG_DARK = 7'h7F;

  // Active-low segment pattern for one BCD code; codes 10..15 show a dash.
  function automatic logic [6:0] bcd_to_seg(input logic [3:0] code);
    logic [6:0] pat;
    case (code)
      4'd0:    pat = 7'h40;
      4'd1:    pat = 7'h79;
      4'd2:    pat = 7'h24;
      4'd3:    pat = 7'h30;
      4'd4:    pat = 7'h19;
      4'd5:    pat = 7'h12;
      4'd6:    pat = 7'h02;
      4'd7:    pat = 7'h78;
      4'd8:    pat = 7'h00;
      4'd9:    pat = 7'h10;
      default: pat = 7'h3F;
    endcase
    return pat;
  endfunction

  logic [DIV_W-1:0]    div_r;
  logic [IDX_W-1:0]    idx_r;
  logic [4*DIGITS-1:0] snap_r;
  logic [6:0]          seg_r;
  logic                dp_r;
  logic [DIGITS-1:0]   an_r;
  logic                frame_done_r;

  logic                div_last_s;
  logic                frame_wrap_s;
  logic [3:0]          code_s;
  logic [DIGITS-1:0]   sel_s;
  logic                blink_dark_s;
  logic                dark_s;

  // Slot/frame boundary detection and the pattern for the current digit.
  always_comb begin
    div_last_s   = (div_r == DIV_LAST);
    frame_wrap_s = div_last_s && (idx_r == IDX_LAST);
    code_s       = snap_r[{idx_r, 2'b00} +: 4];
    sel_s        = {{(DIGITS-1){1'b0}}, 1'b1} << idx_r;
    dark_s       = blank_mask[idx_r] | blink_dark_s;
  end

`ifdef SEG_SCAN_DISPLAY_BLINK_EN
  localparam int FC_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [FC_W-1:0] FC_ZERO = FC_W'(0);
  localparam logic [FC_W-1:0] FC_ONE  = FC_W'(1);
  localparam logic [FC_W-1:0] FC_LAST = FC_W'(BLINK_FRAMES - 1);

  logic [FC_W-1:0] fcnt_r;
  logic            ph_r;

  // Frame counter and blink phase; advanced on the wrap edge so the new
  // phase already applies to the first digit of the next frame.
  always_ff @(posedge clk_cin or posedge rst) begin
    if (rst) begin
      fcnt_r <= FC_ZERO;
      ph_r   <= 1'b0;
    end else if (en && frame_wrap_s) begin
      if (fcnt_r == FC_LAST) begin
        fcnt_r <= FC_ZERO;
        ph_r   <= ~ph_r;
      end else begin
        fcnt_r <= fcnt_r + FC_ONE;
      end
    end
  end

  assign blink_dark_s = blink_sel[idx_r] & ph_r;
`else
  logic blink_sel_unused_s;

  assign blink_sel_unused_s = ^blink_sel;
  assign blink_dark_s       = 1'b0;
`endif

  // Scan divider, digit index and per-frame digit snapshot.
  always_ff @(posedge clk_cin or posedge rst) begin
    if (rst) begin
      div_r  <= DIV_ZERO;
      idx_r  <= IDX_ZERO;
      snap_r <= {(4*DIGITS){1'b0}};
    end else if (en) begin
      if (div_last_s) begin
        div_r <= DIV_ZERO;
        idx_r <= (idx_r == IDX_LAST) ? IDX_ZERO : (idx_r + IDX_ONE);
      end else begin
        div_r <= div_r + DIV_ONE;
      end
      if (frame_wrap_s) begin
        snap_r <= digits_bcd;
      end
    end
  end

  // Registered display outputs; dark whenever scanning is disabled.
  always_ff @(posedge clk_cin or posedge rst) begin
    if (rst) begin
      an_r         <= {DIGITS{1'b1}};
      seg_r        <= SEG_DARK;
      dp_r         <= 1'b1;
      frame_done_r <= 1'b0;
    end else if (en) begin
      an_r         <= ~sel_s;
      seg_r        <= dark_s ? SEG_DARK : bcd_to_seg(code_s);
      dp_r         <= dark_s | ~dp_mask[idx_r];
      frame_done_r <= frame_wrap_s;
    end else begin
      an_r         <= {DIGITS{1'b1}};
      seg_r        <= SEG_DARK;
      dp_r         <= 1'b1;
      frame_done_r <= 1'b0;
    end
  end

  assign seg        = seg_r;
  assign dp         = dp_r;
  assign an         = an_r;
  assign frame_done = frame_done_r;

endmodule
